ula_wb_stage: RTL

ULA_WB_STAGE -- requirements
Module: ula_wb_stage

---
 rtl/ula_wb_stage.sv | 103 ++++++++++
 1 files changed

// File: rtl/ula_wb_stage.sv
// Writeback stage: buffers ALU results in a small FIFO and resolves bne compares
// into a one-cycle redirect pulse; counts retired instructions.
module ula_wb_stage #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_result,
    input  logic       in_zero,
    input  logic [1:0] in_rd,
    input  logic       in_reg_write,
    input  logic       in_is_bne,
    input  logic [7:0] in_target,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_result,
    output logic [1:0] out_rd,
    output logic       out_reg_write,
    output logic       branch_taken,
    output logic [7:0] branch_pc,
    output logic [7:0] retired_count
);

    localparam int DATA_W  = 8;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_W + 3;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem_p1 [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;

    logic accept;
    logic pop;
    logic push;
    logic bne_ok;

    function automatic logic [7:0] retire_next(input logic [7:0] cur,
                                               input logic       pop_ok,
                                               input logic       bne_acc);
        return cur + {7'd0, pop_ok} + {7'd0, bne_acc};
    endfunction

    assign in_ready  = rst_n & (count < FULL);
    assign out_valid = (count != '0);
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;
    assign push      = accept & ~in_is_bne;
    assign bne_ok    = accept & in_is_bne;

    // Stage p1: buffer storage holds data only; validity comes from count
    always_ff @(posedge clk) begin
        if (push) begin
            mem_p1[wptr] <= {in_result, in_rd, in_reg_write};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count         <= '0;
            wptr          <= '0;
            rptr          <= '0;
            branch_taken  <= 1'b0;
            branch_pc     <= '0;
            retired_count <= '0;
        end else if (flush) begin
            // a pop coinciding with flush is dropped, not retired
            count        <= '0;
            wptr         <= '0;
            rptr         <= '0;
            branch_taken <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            branch_taken <= bne_ok & ~in_zero;
            if (bne_ok & ~in_zero) begin
                branch_pc <= in_target;
            end
            retired_count <= retire_next(retired_count, pop, bne_ok);
        end
    end

    assign head          = mem_p1[rptr];
    assign out_result    = out_valid ? head[ENTRY_W-1:3] : '0;
    assign out_rd        = out_valid ? head[2:1] : '0;
    assign out_reg_write = out_valid & head[0];

endmodule
